div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 48, meaning the maximum RUN cycles allowed before the request is aborted.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports reqN_valid  input  1  request from requester N, for N = 0 and 1.
REQ-005 SHALL have ports reqN_dividend  input  32  and  reqN_divisor  input  32  signed operands of requester N.
REQ-006 SHALL have ports reqN_ready  output  1  one-cycle acceptance pulse to requester N.
REQ-007 SHALL have ports rspN_valid  output  1  one-cycle result pulse to requester N.
REQ-008 SHALL have ports rspN_quotient  output  32  and  rspN_exception  output  1  result of requester N.
REQ-009 SHALL have ports div_dividend  output  32  and  div_divisor  output  32  held operands to the divider.
REQ-010 SHALL have port div_reset  output  1  active-high restart of the divider.
REQ-011 SHALL have ports div_quotient  input  32,  div_rdy  input  1  and  div_exception  input  1  from the divider.
REQ-012 SHALL have ports busy  output  1  (state != IDLE) and  timeout  output  1  (one-cycle abort pulse).

Function
REQ-013 SHALL implement the states IDLE, START, RUN and DONE.
REQ-014 IDLE: SHALL grant, if any reqN_valid is high, to the requester selected by round-robin, latch its operands and owner index, pulse reqN_ready for that cycle, and go to START.
REQ-015 SHALL, when both requesters are valid in the same cycle, grant to the requester named by the priority pointer; the pointer then names the other requester.
REQ-016 SHALL keep the priority pointer unchanged when only one requester is valid; the pointer resets to requester 0.
REQ-017 START: SHALL drive div_reset=1 for exactly one cycle, clear the run counter, and go to RUN.
REQ-018 RUN: SHALL drive div_reset=0 and increment the run counter each cycle.
REQ-019 RUN: SHALL, when div_rdy=1, capture div_quotient and div_exception and go to DONE.
REQ-020 RUN: SHALL, when the run counter reaches TIMEOUT_CYCLES with div_rdy=0, load quotient 0 and exception 1, pulse timeout, and go to DONE.
REQ-021 DONE: SHALL pulse rspN_valid to the owner for one cycle and return to IDLE; no grant occurs in the DONE cycle.
REQ-022 SHALL hold div_dividend and div_divisor stable from START through DONE.
REQ-023 SHALL hold rspN_quotient and rspN_exception at their last delivered value until the next response to that requester.
REQ-024 SHALL, with a 32-step divider, assert rsp_valid 35 cycles after the acceptance cycle.
REQ-025 SHALL ignore reqN_valid outside IDLE; requesters must hold valid and operands until reqN_ready.
REQ-026 SHALL pass div_rdy through unchanged in START.
REQ-027 SHALL ignore div_rdy outside RUN.

Reset
REQ-028 SHALL, on reset=0 at a clock edge, enter IDLE and set the priority pointer to 0.
REQ-029 SHALL, on reset, zero the run counter, held operands, quotients and exceptions.
REQ-030 SHALL, on reset, deassert all reqN_ready, rspN_valid and timeout.
REQ-031 SHALL drive div_reset=1 while reset=0.
REQ-032 SHALL, on reset mid-operation, discard the request in flight and issue no response.

Configuration
REQ-033 SHALL use macro DIV_ZERO_FASTPATH_EN for a zero-divisor fast path.
REQ-034 With DIV_ZERO_FASTPATH_EN defined, SHALL send a granted request with divisor 0 from IDLE directly to DONE with quotient 0 and exception 1, delivering rsp_valid in the cycle after acceptance without pulsing div_reset.
REQ-035 Without DIV_ZERO_FASTPATH_EN, SHALL run zero-divisor requests through the divider and report div_exception.

Structure
REQ-036 SHALL place the state encoding, the TIMEOUT_CYCLES default and the requester-index width in shared package div_arb_pkg.
REQ-037 SHALL implement the two-input round-robin grant as sub-module rr_arbiter2, with inputs request[1:0], advance and reset, and outputs grant[1:0].

Verification
REQ-038 Single request: req0 100/7 -> req0_ready at T, one div_reset pulse at T+1, rsp0_valid at T+35 with quotient 14 and exception 0.
REQ-039 Simultaneous requests: req0 -20/3 and req1 9/-2 after reset -> req0 served first (quotient -6), then req1 (quotient -4); the pointer then favours req0.
REQ-040 Zero divisor: req1 5/0 -> with the macro, rsp1_valid at T+1 with quotient 0, exception 1 and no div_reset pulse; without it, rsp1_valid at T+35 with exception 1.
REQ-041 Timeout: divider model that never raises div_rdy -> timeout pulse after 48 RUN cycles, then rsp with quotient 0 and exception 1, then back to IDLE.
REQ-042 Reset mid-RUN: reset=0 on RUN cycle 10 -> no rsp_valid, busy=0 the next cycle, and a following request completes normally.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 48;
  localparam int IDX_W                  = 1;
  localparam int RUN_CNT_W              = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a one-bit priority pointer.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] request,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_q, prio_d;

  // Pointer only moves on a contested grant, so a lone requester never steals the turn.
  always_comb begin
    grant  = request;
    prio_d = prio_q;
    if (request == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
      if (advance) begin
        prio_d = ~prio_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters with timeout supervision.
// Optional DIV_ZERO_FASTPATH_EN answers zero-divisor requests without using the divider.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_dividend,
  input  logic [31:0] req0_divisor,
  input  logic        req1_valid,
  input  logic [31:0] req1_dividend,
  input  logic [31:0] req1_divisor,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp0_quotient,
  output logic        rsp0_exception,
  output logic [31:0] rsp1_quotient,
  output logic        rsp1_exception,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_reset,
  input  logic [31:0] div_quotient,
  input  logic        div_rdy,
  input  logic        div_exception,
  output logic        busy,
  output logic        timeout
);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [31:0]            dividend_q, dividend_d;
  logic [31:0]            divisor_q, divisor_d;
  logic [RUN_CNT_W-1:0]   runCnt_q, runCnt_d;
  logic [1:0][31:0]       rspQuot_q, rspQuot_d;
  logic [1:0]             rspExc_q, rspExc_d;

  logic [1:0] grant;
  logic [1:0] grantPulse;
  logic [1:0] rspPulse;
  logic       startPulse;
  logic       timeoutPulse;
  logic       advance;

  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .request ({req1_valid, req0_valid}),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    runCnt_d     = runCnt_q;
    rspQuot_d    = rspQuot_q;
    rspExc_d     = rspExc_q;
    grantPulse   = 2'b00;
    rspPulse     = 2'b00;
    startPulse   = 1'b0;
    timeoutPulse = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      IDLE: begin
        advance = 1'b1;
        if (|grant) begin
          grantPulse = grant;
          owner_d    = IDX_W'(grant[1]);
          dividend_d = grant[1] ? req1_dividend : req0_dividend;
          divisor_d  = grant[1] ? req1_divisor  : req0_divisor;
          state_d    = START;
`ifdef DIV_ZERO_FASTPATH_EN
          if (divisor_d == 32'd0) begin
            rspQuot_d[owner_d] = 32'd0;
            rspExc_d[owner_d]  = 1'b1;
            state_d            = DONE;
          end
`endif
        end
      end
      START: begin
        startPulse = 1'b1;
        runCnt_d   = '0;
        state_d    = RUN;
      end
      RUN: begin
        runCnt_d = runCnt_q + 1'b1;
        // Results land straight in the owner's output registers so DONE can present them.
        if (div_rdy) begin
          rspQuot_d[owner_q] = div_quotient;
          rspExc_d[owner_q]  = div_exception;
          state_d            = DONE;
        end else if (runCnt_q == RUN_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rspQuot_d[owner_q] = 32'd0;
          rspExc_d[owner_q]  = 1'b1;
          timeoutPulse       = 1'b1;
          state_d            = DONE;
        end
      end
      DONE: begin
        rspPulse[owner_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      runCnt_q   <= '0;
      rspQuot_q  <= '0;
      rspExc_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      runCnt_q   <= runCnt_d;
      rspQuot_q  <= rspQuot_d;
      rspExc_q   <= rspExc_d;
    end
  end

  // Pulses are masked while reset is held so nothing escapes during the reset cycle.
  assign req0_ready     = reset & grantPulse[0];
  assign req1_ready     = reset & grantPulse[1];
  assign rsp0_valid     = reset & rspPulse[0];
  assign rsp1_valid     = reset & rspPulse[1];
  assign timeout        = reset & timeoutPulse;
  assign div_reset      = ~reset | startPulse;
  assign busy           = (state_q != IDLE);
  assign div_dividend   = dividend_q;
  assign div_divisor    = divisor_q;
  assign rsp0_quotient  = rspQuot_q[0];
  assign rsp0_exception = rspExc_q[0];
  assign rsp1_quotient  = rspQuot_q[1];
  assign rsp1_exception = rspExc_q[1];

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: table-driven requests, scoreboard per requester,
// plus hand-written arbitration, timeout and mid-RUN reset sequences.
module tb_div_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0Valid = 1'b0, req1Valid = 1'b0;
  logic [31:0] req0Dividend = '0, req0Divisor = '0;
  logic [31:0] req1Dividend = '0, req1Divisor = '0;
  logic        req0Ready, req1Ready, rsp0Valid, rsp1Valid;
  logic [31:0] rsp0Quotient, rsp1Quotient;
  logic        rsp0Exception, rsp1Exception;
  logic [31:0] divDividend, divDivisor, divQuotient;
  logic        divReset, divRdy, divException, busy, timeout;

  div_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0Valid),
    .req0_dividend (req0Dividend),
    .req0_divisor  (req0Divisor),
    .req1_valid    (req1Valid),
    .req1_dividend (req1Dividend),
    .req1_divisor  (req1Divisor),
    .req0_ready    (req0Ready),
    .req1_ready    (req1Ready),
    .rsp0_valid    (rsp0Valid),
    .rsp1_valid    (rsp1Valid),
    .rsp0_quotient (rsp0Quotient),
    .rsp0_exception(rsp0Exception),
    .rsp1_quotient (rsp1Quotient),
    .rsp1_exception(rsp1Exception),
    .div_dividend  (divDividend),
    .div_divisor   (divDivisor),
    .div_reset     (divReset),
    .div_quotient  (divQuotient),
    .div_rdy       (divRdy),
    .div_exception (divException),
    .busy          (busy),
    .timeout       (timeout)
  );

  always #5 clock = ~clock;

  // 32-step divider model; neverRdy models a hung divider.
  int   dcnt = 0;
  logic neverRdy = 1'b0;
  logic signed [31:0] sDividend, sDivisor;
  always @(posedge clock) begin
    if (divReset) dcnt <= 0;
    else if (dcnt < 60) dcnt <= dcnt + 1;
  end
  assign sDividend    = divDividend;
  assign sDivisor     = divDivisor;
  assign divRdy       = !divReset && !neverRdy && (dcnt == 32);
  assign divException = (divDivisor == 32'd0);
  always_comb begin
    divQuotient = 32'd0;
    if (divDivisor != 32'd0) divQuotient = sDividend / sDivisor;
  end

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] expQuot;
    logic        expExc;
    int          expLat;
    int          expDivRst;
    int          expTimeout;
  } sbItem_t;

  sbItem_t sb0[$];
  sbItem_t sb1[$];

  typedef struct {
    int idx;
    int dividend;
    int divisor;
    int expQuot;
    logic expExc;
  } vec_t;

  vec_t vecs[8];

  // Monitor: tracks the in-flight transaction and scores every response.
  int cyc = 0, acceptCyc = 0, drCount = 0, toCount = 0;
  int grantLog[$];

  task automatic checkOutput(input int idx);
    sbItem_t it;
    if ((idx == 0 && sb0.size() == 0) || (idx == 1 && sb1.size() == 0)) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL unexpected rsp%0d: got valid expected none", idx);
      return;
    end
    it = (idx == 0) ? sb0.pop_front() : sb1.pop_front();
    checkEq($sformatf("rsp%0d quotient", idx), idx == 0 ? rsp0Quotient : rsp1Quotient, it.expQuot);
    checkEq($sformatf("rsp%0d exception", idx), idx == 0 ? rsp0Exception : rsp1Exception, it.expExc);
    checkEq($sformatf("rsp%0d latency", idx), cyc - acceptCyc, it.expLat);
    checkEq($sformatf("rsp%0d div_reset pulses", idx), drCount, it.expDivRst);
    checkEq($sformatf("rsp%0d timeout pulses", idx), toCount, it.expTimeout);
    checkEq($sformatf("rsp%0d held dividend", idx), divDividend, it.dividend);
    checkEq($sformatf("rsp%0d held divisor", idx), divDivisor, it.divisor);
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      if (req0Ready || req1Ready) begin
        acceptCyc = cyc;
        drCount   = 0;
        toCount   = 0;
        grantLog.push_back(req1Ready ? 1 : 0);
        if (req0Ready && req1Ready) checkEq("single grant", 2, 1);
      end else begin
        if (divReset) drCount++;
        if (timeout)  toCount++;
      end
      if (rsp0Valid) checkOutput(0);
      if (rsp1Valid) checkOutput(1);
    end
  end

  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expQ, input logic expE,
                               input bit expectRsp, input bit timeoutCase);
    sbItem_t it;
    bit got;
    bit fast;
    fast = 1'b0;
`ifdef DIV_ZERO_FASTPATH_EN
    fast = (b == 32'd0);
`endif
    it.dividend   = a;
    it.divisor    = b;
    it.expQuot    = expQ;
    it.expExc     = expE;
    it.expLat     = timeoutCase ? 50 : (fast ? 1 : 35);
    it.expDivRst  = fast ? 0 : 1;
    it.expTimeout = timeoutCase ? 1 : 0;
    @(posedge clock);
    #1;
    if (expectRsp) begin
      if (idx == 0) sb0.push_back(it);
      else          sb1.push_back(it);
    end
    if (idx == 0) begin
      req0Valid = 1'b1; req0Dividend = a; req0Divisor = b;
    end else begin
      req1Valid = 1'b1; req1Dividend = b == b ? a : a; req1Divisor = b;
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      got = (idx == 0) ? req0Ready : req1Ready;
    end
    checkEq($sformatf("req%0d accepted", idx), got, 1'b1);
    @(posedge clock);
    #1;
    if (idx == 0) req0Valid = 1'b0;
    else          req1Valid = 1'b0;
  endtask

  task automatic waitDrain(input int maxCyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCyc && !done; i++) begin
      @(negedge clock);
      done = (sb0.size() == 0) && (sb1.size() == 0) && !busy;
    end
    if (!done) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL drain: got busy=%0b pending=%0d expected idle", busy, sb0.size() + sb1.size());
      sb0.delete();
      sb1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] lastQ[2];
    lastQ[0] = 32'd0;
    lastQ[1] = 32'd0;

    vecs[0] = '{0, 100, 7, 14, 1'b0};
    vecs[1] = '{1, 5, 0, 0, 1'b1};
    vecs[2] = '{1, 1000, -10, -100, 1'b0};
    vecs[3] = '{0, -49, 7, -7, 1'b0};
    vecs[4] = '{1, 0, 5, 0, 1'b0};
    vecs[5] = '{0, 2147483647, 1, 2147483647, 1'b0};
    vecs[6] = '{1, -1, 2, 0, 1'b0};
    vecs[7] = '{0, -100, -7, 14, 1'b0};

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkEq("reset busy", busy, 1'b0);
    checkEq("reset ready", {req1Ready, req0Ready}, 2'b00);
    checkEq("reset rsp valid", {rsp1Valid, rsp0Valid}, 2'b00);
    checkEq("reset timeout", timeout, 1'b0);
    checkEq("reset div_reset", divReset, 1'b1);
    checkEq("reset rsp0 quotient", rsp0Quotient, 32'd0);
    checkEq("reset rsp1 exception", rsp1Exception, 1'b0);
    checkEq("reset held dividend", divDividend, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkEq("idle div_reset", divReset, 1'b0);

    // Simultaneous requests: expected grant order 0,1,0 then lone 1.
    grantLog.delete();
    fork
      begin
        applyStimulus(0, -20, 3, -6, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 1000, -10, -100, 1'b0, 1'b1, 1'b0);
      end
      begin
        applyStimulus(1, 9, -2, -4, 1'b0, 1'b1, 1'b0);
        applyStimulus(1, -49, 7, -7, 1'b0, 1'b1, 1'b0);
      end
    join
    waitDrain(200);
    checkEq("grant count", grantLog.size(), 4);
    if (grantLog.size() == 4) begin
      checkEq("grant order 0", grantLog[0], 0);
      checkEq("grant order 1", grantLog[1], 1);
      checkEq("grant order 2", grantLog[2], 0);
      checkEq("grant order 3", grantLog[3], 1);
    end
    lastQ[0] = -100;
    lastQ[1] = -7;

    // Table-driven single requests.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].dividend, vecs[i].divisor,
                    vecs[i].expQuot, vecs[i].expExc, 1'b1, 1'b0);
      waitDrain(100);
      lastQ[vecs[i].idx] = vecs[i].expQuot;
      checkEq($sformatf("vec%0d other rsp held", i),
              vecs[i].idx == 0 ? rsp1Quotient : rsp0Quotient, lastQ[1 - vecs[i].idx]);
    end

    // Hung divider: timeout path.
    neverRdy = 1'b1;
    applyStimulus(0, 77, 3, 0, 1'b1, 1'b1, 1'b1);
    waitDrain(100);
    neverRdy = 1'b0;
    checkEq("timeout idle", timeout, 1'b0);

    // Reset on RUN cycle 10 discards the request.
    applyStimulus(1, 50, 5, 10, 1'b0, 1'b0, 1'b0);
    repeat (11) @(posedge clock);
    @(negedge clock);
    checkEq("mid-run busy", busy, 1'b1);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkEq("post-reset busy", busy, 1'b0);
    checkEq("post-reset rsp0 quotient", rsp0Quotient, 32'd0);
    checkEq("post-reset rsp0 exception", rsp0Exception, 1'b0);
    repeat (40) @(negedge clock);
    applyStimulus(1, 50, 5, 10, 1'b0, 1'b1, 1'b0);
    waitDrain(100);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
